// File: rtl/gcd_requester_if.sv
// Handshake bundle between gcd_requester and its upstream, engine and downstream peers.
// master is the requester's view; slave is the view of the surrounding peers.
interface gcd_requester_if #(
    parameter int W    = 16,
    parameter int TAGW = 4
);
    logic            cmd_val;
    logic            cmd_rdy;
    logic [W-1:0]    cmd_a;
    logic [W-1:0]    cmd_b;
    logic            req_val;
    logic            req_rdy;
    logic [W-1:0]    req_a;
    logic [W-1:0]    req_b;
    logic            resp_val;
    logic            resp_rdy;
    logic [W-1:0]    resp_data;
    logic            out_val;
    logic            out_rdy;
    logic [W-1:0]    out_data;
    logic [TAGW-1:0] out_tag;
    logic            busy;
    logic            timeout_err;

    modport master (
        input  cmd_val, cmd_a, cmd_b, req_rdy, resp_val, resp_data, out_rdy,
        output cmd_rdy, req_val, req_a, req_b, resp_rdy, out_val, out_data, out_tag,
               busy, timeout_err
    );

    modport slave (
        output cmd_val, cmd_a, cmd_b, req_rdy, resp_val, resp_data, out_rdy,
        input  cmd_rdy, req_val, req_a, req_b, resp_rdy, out_val, out_data, out_tag,
               busy, timeout_err
    );
endinterface

// File: rtl/gcd_requester.sv
// Sequences one GCD operation at a time: accept command, issue to engine, await result, deliver tagged.
// Optional WAIT watchdog enabled by defining GCD_REQ_TIMEOUT_EN (TIMEOUT must then be >= 1).
module gcd_requester #(
    parameter int W       = 16,
    parameter int TAGW    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    gcd_requester_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t          state_r;
    logic            cmd_rdy_r;
    logic            req_val_r;
    logic            resp_rdy_r;
    logic            out_val_r;
    logic            busy_r;
    logic [W-1:0]    req_a_r;
    logic [W-1:0]    req_b_r;
    logic [W-1:0]    out_data_r;
    logic [TAGW-1:0] out_tag_r;
    logic            timeout_err_r;
    logic            both_zero_s;

    assign both_zero_s = (bus.cmd_a == {W{1'b0}}) && (bus.cmd_b == {W{1'b0}});

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wait_cnt_r;
`endif

    // Single FSM: every handshake output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            cmd_rdy_r     <= 1'b1;
            req_val_r     <= 1'b0;
            resp_rdy_r    <= 1'b0;
            out_val_r     <= 1'b0;
            busy_r        <= 1'b0;
            req_a_r       <= {W{1'b0}};
            req_b_r       <= {W{1'b0}};
            out_data_r    <= {W{1'b0}};
            out_tag_r     <= {TAGW{1'b0}};
            timeout_err_r <= 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
            wait_cnt_r    <= {CW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_val) begin
                        req_a_r       <= bus.cmd_a;
                        req_b_r       <= bus.cmd_b;
                        timeout_err_r <= 1'b0;
                        cmd_rdy_r     <= 1'b0;
                        busy_r        <= 1'b1;
                        // gcd(0,0) needs no engine round-trip
                        if (both_zero_s) begin
                            out_data_r <= {W{1'b0}};
                            out_val_r  <= 1'b1;
                            state_r    <= DELIVER;
                        end else begin
                            req_val_r  <= 1'b1;
                            state_r    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.req_rdy) begin
                        req_val_r  <= 1'b0;
                        resp_rdy_r <= 1'b1;
                        state_r    <= WAIT;
`ifdef GCD_REQ_TIMEOUT_EN
                        wait_cnt_r <= {CW{1'b0}};
`endif
                    end
                end
                WAIT: begin
                    // A response arriving on the final watchdog cycle takes priority over the abort.
                    if (bus.resp_val) begin
                        resp_rdy_r <= 1'b0;
                        out_data_r <= bus.resp_data;
                        out_val_r  <= 1'b1;
                        state_r    <= DELIVER;
                    end
`ifdef GCD_REQ_TIMEOUT_EN
                    else if (wait_cnt_r == WAIT_LAST) begin
                        resp_rdy_r    <= 1'b0;
                        out_data_r    <= {W{1'b0}};
                        out_val_r     <= 1'b1;
                        timeout_err_r <= 1'b1;
                        state_r       <= DELIVER;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
`endif
                end
                DELIVER: begin
                    if (bus.out_rdy) begin
                        out_val_r <= 1'b0;
                        out_tag_r <= out_tag_r + 1'b1;
                        cmd_rdy_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cmd_rdy_r  <= 1'b1;
                    req_val_r  <= 1'b0;
                    resp_rdy_r <= 1'b0;
                    out_val_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_rdy  = cmd_rdy_r;
    assign bus.req_val  = req_val_r;
    assign bus.req_a    = req_a_r;
    assign bus.req_b    = req_b_r;
    assign bus.resp_rdy = resp_rdy_r;
    assign bus.out_val  = out_val_r;
    assign bus.out_data = out_data_r;
    assign bus.out_tag  = out_tag_r;
    assign bus.busy     = busy_r;

`ifdef GCD_REQ_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_r;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester; the bench itself plays upstream, GCD engine and downstream.
module tb_gcd_requester;

    localparam int W    = 16;
    localparam int TAGW = 4;
`ifdef GCD_REQ_TIMEOUT_EN
    localparam int TO   = 8;
`else
    localparam int TO   = 255;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    gcd_requester_if #(.W(W), .TAGW(TAGW)) bus ();

    gcd_requester #(.W(W), .TAGW(TAGW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int max_cycles);
        int n;
        n = 0;
        while (bus.out_val !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        chk("out_val_arrives", {31'd0, bus.out_val}, 32'd1);
    endtask

    task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.cmd_val = 1'b1;
        bus.cmd_a   = a;
        bus.cmd_b   = b;
        step();
        bus.cmd_val = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.cmd_val = 1'b0; bus.cmd_a = 16'd0; bus.cmd_b = 16'd0;
        bus.req_rdy = 1'b0; bus.resp_val = 1'b0; bus.resp_data = 16'd0;
        bus.out_rdy = 1'b0;
        @(negedge clk);
        step();
        chk("rst_out_val",  {31'd0, bus.out_val}, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
        chk("rst_out_tag",  {28'd0, bus.out_tag}, 32'd0);
        chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_req_a",    {16'd0, bus.req_a}, 32'd0);
        chk("rst_req_val",  {31'd0, bus.req_val}, 32'd0);
        chk("rst_tmo_err",  {31'd0, bus.timeout_err}, 32'd0);
        reset = 1'b1;
        chk("rst_cmd_rdy",  {31'd0, bus.cmd_rdy}, 32'd1);

        // gcd(48,18): engine answers 6 five cycles into WAIT
        bus.req_rdy = 1'b1; bus.out_rdy = 1'b1;
        send_cmd(16'd48, 16'd18);
        chk("t1_req_val", {31'd0, bus.req_val}, 32'd1);
        chk("t1_req_a",   {16'd0, bus.req_a}, 32'd48);
        chk("t1_req_b",   {16'd0, bus.req_b}, 32'd18);
        chk("t1_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("t1_busy",    {31'd0, bus.busy}, 32'd1);
        step();
        chk("t1_resp_rdy", {31'd0, bus.resp_rdy}, 32'd1);
        chk("t1_req_val0", {31'd0, bus.req_val}, 32'd0);
        repeat (4) step();
        chk("t1_no_out_yet", {31'd0, bus.out_val}, 32'd0);
        bus.resp_val = 1'b1; bus.resp_data = 16'd6;
        step();
        bus.resp_val = 1'b0;
        chk("t1_out_val",  {31'd0, bus.out_val}, 32'd1);
        chk("t1_out_data", {16'd0, bus.out_data}, 32'd6);
        chk("t1_out_tag",  {28'd0, bus.out_tag}, 32'd0);
        chk("t1_resp_rdy0", {31'd0, bus.resp_rdy}, 32'd0);
        step();
        chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("t1_idle_rdy",  {31'd0, bus.cmd_rdy}, 32'd1);
        chk("t1_tag_inc",   {28'd0, bus.out_tag}, 32'd1);

        // (0,0) bypasses the engine and delivers 0 one cycle later
        send_cmd(16'd0, 16'd0);
        chk("byp_req_val",  {31'd0, bus.req_val}, 32'd0);
        chk("byp_out_val",  {31'd0, bus.out_val}, 32'd1);
        chk("byp_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("byp_out_tag",  {28'd0, bus.out_tag}, 32'd1);
        step();

        // single zero operand goes through the engine; all peers ready -> 3 cycle latency
        bus.resp_val = 1'b1; bus.resp_data = 16'd12;
        send_cmd(16'd12, 16'd0);
        chk("z1_req_val", {31'd0, bus.req_val}, 32'd1);
        chk("z1_req_b",   {16'd0, bus.req_b}, 32'd0);
        step();
        chk("z1_out_early", {31'd0, bus.out_val}, 32'd0);
        step();
        chk("z1_out_val",  {31'd0, bus.out_val}, 32'd1);
        chk("z1_out_data", {16'd0, bus.out_data}, 32'd12);
        step();
        bus.resp_val = 1'b0;

        // back-pressure: req_rdy low 4 cycles, out_rdy low 3 cycles
        bus.req_rdy = 1'b0; bus.out_rdy = 1'b0;
        send_cmd(16'd21, 16'd6);
        for (int k = 0; k < 4; k++) begin
            chk("bp_req_val", {31'd0, bus.req_val}, 32'd1);
            chk("bp_req_ab",  {bus.req_a, bus.req_b}, {16'd21, 16'd6});
            step();
        end
        bus.req_rdy = 1'b1;
        chk("bp_req_still", {31'd0, bus.req_val}, 32'd1);
        step();
        bus.resp_val = 1'b1; bus.resp_data = 16'd3;
        step();
        bus.resp_val = 1'b0;
        bus.cmd_val = 1'b1; bus.cmd_a = 16'd99; bus.cmd_b = 16'd0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_out_val",  {31'd0, bus.out_val}, 32'd1);
            chk("bp_out_hold", {12'd0, bus.out_tag, bus.out_data}, {12'd0, 4'd3, 16'd3});
            chk("bp_cmd_rdy0", {31'd0, bus.cmd_rdy}, 32'd0);
            step();
        end
        bus.out_rdy = 1'b1;
        step();
        chk("bp_idle_tag", {28'd0, bus.out_tag}, 32'd4);
        chk("bp_no_early", {16'd0, bus.req_a}, 32'd21);
        step();
        bus.cmd_val = 1'b0;
        chk("bp_next_cmd", {16'd0, bus.req_a}, 32'd99);
        bus.resp_val = 1'b1; bus.resp_data = 16'd99;
        wait_out(6);
        chk("bp_next_data", {16'd0, bus.out_data}, 32'd99);
        step();
        bus.resp_val = 1'b0;

        // reset while in WAIT abandons the operation
        send_cmd(16'd35, 16'd14);
        step();
        chk("rw_in_wait", {31'd0, bus.resp_rdy}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rw_out_val", {31'd0, bus.out_val}, 32'd0);
        chk("rw_busy",    {31'd0, bus.busy}, 32'd0);
        chk("rw_tag",     {28'd0, bus.out_tag}, 32'd0);
        chk("rw_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        step();
        chk("rw_still_quiet", {31'd0, bus.out_val}, 32'd0);
        bus.resp_val = 1'b1; bus.resp_data = 16'd7;
        send_cmd(16'd35, 16'd14);
        wait_out(6);
        chk("rw_out_data", {16'd0, bus.out_data}, 32'd7);
        chk("rw_out_tag",  {28'd0, bus.out_tag}, 32'd0);
        step();

        // 17 back-to-back commands: tag walks 0..15 then wraps to 0
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.resp_data = 16'(100 + i);
            send_cmd(16'(i + 1), 16'd5);
            wait_out(6);
            chk("wrap_tag",  {28'd0, bus.out_tag}, 32'(i % 16));
            chk("wrap_data", {16'd0, bus.out_data}, 32'(100 + i));
            step();
        end
        bus.resp_val = 1'b0;

`ifdef GCD_REQ_TIMEOUT_EN
        // engine silent: abort after exactly 8 WAIT cycles
        send_cmd(16'd9, 16'd6);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("to_wait_quiet", {30'd0, bus.out_val, bus.timeout_err}, 32'd0);
            step();
        end
        bus.out_rdy = 1'b0;
        chk("to_out_val",  {31'd0, bus.out_val}, 32'd1);
        chk("to_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("to_err",      {31'd0, bus.timeout_err}, 32'd1);
        bus.out_rdy = 1'b1;
        step();
        chk("to_err_held", {31'd0, bus.timeout_err}, 32'd1);
        bus.resp_val = 1'b1; bus.resp_data = 16'd3;
        send_cmd(16'd9, 16'd6);
        chk("to_err_clear", {31'd0, bus.timeout_err}, 32'd0);
        wait_out(6);
        chk("to_ok_data", {16'd0, bus.out_data}, 32'd3);
        step();
        bus.resp_val = 1'b0;
        // response on the final watchdog cycle beats the abort
        send_cmd(16'd10, 16'd15);
        step();
        repeat (7) step();
        bus.resp_val = 1'b1; bus.resp_data = 16'd5;
        step();
        bus.resp_val = 1'b0;
        chk("race_data", {16'd0, bus.out_data}, 32'd5);
        chk("race_err",  {31'd0, bus.timeout_err}, 32'd0);
        step();
`else
        // no watchdog: WAIT persists well past the would-be timeout
        send_cmd(16'd9, 16'd6);
        step();
        repeat (300) step();
        chk("nto_still_wait", {31'd0, bus.resp_rdy}, 32'd1);
        chk("nto_no_out",     {30'd0, bus.out_val, bus.timeout_err}, 32'd0);
        bus.resp_val = 1'b1; bus.resp_data = 16'd3;
        step();
        bus.resp_val = 1'b0;
        chk("nto_out_data", {16'd0, bus.out_data}, 32'd3);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
